// File: rtl/issue_ctrl.sv
// Issue-stage scheduler: gates instruction issue, allocates ROB tags and tracks
// ROB head/tail/occupancy, with a fixed-length flush window after rollback.
module issue_ctrl #(
   parameter int ROB_DEPTH    = 16,
   parameter int TAG_W        = 5,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              rollback,
   input  logic              inst_valid,
   output logic              inst_ready,
   input  logic              needs_rs,
   input  logic              needs_lsb,
   input  logic              rs_full,
   input  logic              lsb_full,
   input  logic              commit_sgn,
   output logic              issue_sgn,
   output logic [TAG_W-1:0]  rob_new_entry,
   output logic [TAG_W-1:0]  rob_head,
   output logic [TAG_W:0]    rob_count,
   output logic              rob_full,
   output logic              rob_empty,
   output logic              commit_err,
   output logic [31:0]       stall_cycles
);

   localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [TAG_W-1:0] NULL_TAG  = TAG_W'(ROB_DEPTH);
   localparam logic [TAG_W-1:0] LAST_TAG  = TAG_W'(ROB_DEPTH - 1);
   localparam logic [TAG_W:0]   DEPTH_CNT = (TAG_W + 1)'(ROB_DEPTH);
   localparam logic [FC_W-1:0]  LAST_FC   = FC_W'(FLUSH_CYCLES - 1);

   typedef enum logic {RUN, FLUSH} state_t;

   state_t            state_q, state_d;
   logic [TAG_W-1:0]  head_q, head_d, tail_q, tail_d;
   logic [TAG_W:0]    count_q, count_d;
   logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
   logic              err_q, err_d;
   logic [31:0]       stall_q, stall_d;
   logic              commit_eff, stall_now;

   function automatic logic [TAG_W-1:0] wrap_inc(input logic [TAG_W-1:0] t);
      return (t == LAST_TAG) ? '0 : t + 1'b1;
   endfunction

   assign rob_full   = (count_q == DEPTH_CNT);
   assign rob_empty  = (count_q == '0);
   // Full ROB blocks issue even when a commit frees a slot in the same cycle.
   assign inst_ready = (state_q == RUN) & rdy & !rollback & !rob_full
                       & !(needs_rs & rs_full) & !(needs_lsb & lsb_full);
   assign issue_sgn  = inst_valid & inst_ready;
   assign commit_eff = (state_q == RUN) & rdy & !rollback & commit_sgn & !rob_empty;
   assign stall_now  = inst_valid & !inst_ready & rdy & !rollback;

   assign rob_new_entry = issue_sgn ? tail_q : NULL_TAG;
   assign rob_head      = head_q;
   assign rob_count     = count_q;
   assign commit_err    = err_q;
   assign stall_cycles  = stall_q;

   always_comb begin
      state_d     = state_q;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      flush_cnt_d = flush_cnt_q;
      err_d       = err_q;
      stall_d     = stall_q;
      if (rollback) begin
         state_d     = FLUSH;
         head_d      = '0;
         tail_d      = '0;
         count_d     = '0;
         flush_cnt_d = '0;
      end else if (rdy) begin
         if (stall_now && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
         if (state_q == FLUSH) begin
            if (flush_cnt_q == LAST_FC) begin
               state_d     = RUN;
               flush_cnt_d = '0;
            end else begin
               flush_cnt_d = flush_cnt_q + 1'b1;
            end
         end else begin
            if (commit_sgn && rob_empty) err_d = 1'b1;
            if (issue_sgn)  tail_d = wrap_inc(tail_q);
            if (commit_eff) head_d = wrap_inc(head_q);
            count_d = count_q + {{TAG_W{1'b0}}, issue_sgn} - {{TAG_W{1'b0}}, commit_eff};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         flush_cnt_q <= '0;
         err_q       <= 1'b0;
         stall_q     <= '0;
      end else begin
         state_q     <= state_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         flush_cnt_q <= flush_cnt_d;
         err_q       <= err_d;
         stall_q     <= stall_d;
      end
   end

endmodule
